// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmitter. The receiver uses the same
// state names, line levels and parity-type encoding, so both sides agree on
// the frame format.
//   tx_state_e    : transmitter FSM states
//   *_LVL         : serial line levels for idle, start and stop
//   PAR_EVEN/ODD  : encoding of the PAR_TYP input
//   eff_prescale  : maps a PRESCALE of 0 to 1 cycle per bit
//   parity_bit    : parity bit from the XOR-reduction of the data word
// ---------------------------------------------------------------------------
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_W = 6;

  // A zero prescale would never hit the terminal count, so it runs as 1.
  function automatic logic [PRESCALE_W-1:0] eff_prescale(
    input logic [PRESCALE_W-1:0] p
  );
    if (p == '0) begin
      return {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
    return p;
  endfunction

  // Even parity sends the XOR of the data bits, odd parity its complement.
  function automatic logic parity_bit(
    input logic xor_red,
    input logic par_typ
  );
    return (par_typ == PAR_ODD) ? ~xor_red : xor_red;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// DSIZE-bit shift register that feeds the data bits of a frame, LSB first.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   load_i  : capture data_i (frame acceptance)
//   data_i  : parallel word to serialise
//   shift_i : discard the current LSB and move the next bit down
//   lsb_o   : current LSB, the next data bit to be driven on the line
// ---------------------------------------------------------------------------
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DSIZE-1:0] data_i,
  input  logic             shift_i,
  output logic             lsb_o
);

  logic [DSIZE-1:0] shreg_q;
  logic [DSIZE-1:0] shreg_d;

  // Load has priority: on a back-to-back frame the new word is captured on
  // the same edge that the previous frame's stop bit ends.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {IDLE_LVL, shreg_q[DSIZE-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign lsb_o = shreg_q[0];

endmodule

// File: rtl/uart_tx_top.sv
// ---------------------------------------------------------------------------
// uart_tx_top
// UART transmitter: start bit, DSIZE data bits LSB first, optional parity
// bit, one stop bit. Each bit lasts PRESCALE cycles (0 behaves as 1).
//   CLK        : system clock
//   RST        : asynchronous active-high reset
//   P_DATA     : word to transmit, sampled at acceptance
//   DATA_VALID : transmit request, accepted when idle or as the stop bit ends
//   PAR_EN     : insert a parity bit, sampled at acceptance
//   PAR_TYP    : 0 even / 1 odd parity, sampled at acceptance
//   PRESCALE   : clock cycles per bit, sampled at acceptance
//   TX_OUT     : registered serial line, idles high
//   BUSY       : registered, high while a frame is in flight
// ---------------------------------------------------------------------------
module uart_tx_top
  import uart_tx_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DSIZE-1:0]      P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int BIT_W = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DSIZE - 1);

  tx_state_e             state_q;
  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [BIT_W-1:0]      bit_q;
  logic                  par_en_q;
  logic                  par_q;
  logic                  tx_q;
  logic                  busy_q;

  logic bit_end;
  logic accept;
  logic ser_shift;
  logic ser_lsb;

  // Last cycle of the current bit period. prescale_q is never 0 outside
  // IDLE, so the subtraction cannot wrap while it matters.
  assign bit_end = (state_q != IDLE) && (cnt_q == (prescale_q - 1'b1));

  // A request is taken when idle, or on the edge that ends a stop bit so
  // that consecutive frames have no idle gap between them.
  assign accept = DATA_VALID &&
                  ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  // TX_OUT is registered, so the serializer is one bit ahead of the line:
  // its LSB is copied to tx_q on the edge that starts each data bit, and
  // the register shifts on that same edge to expose the following bit.
  assign ser_shift = bit_end &&
                     ((state_q == START) ||
                      ((state_q == DATA) && (bit_q != LAST_BIT)));

  uart_tx_serializer #(
    .DSIZE (DSIZE)
  ) u_serializer (
    .clk     (CLK),
    .rst     (RST),
    .load_i  (accept),
    .data_i  (P_DATA),
    .shift_i (ser_shift),
    .lsb_o   (ser_lsb)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prescale_q <= '0;
      bit_q      <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= IDLE_LVL;
      busy_q     <= 1'b0;
    end else begin
      // Bit-period counter: wraps only through the terminal compare.
      if (state_q != IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          tx_q   <= IDLE_LVL;
          busy_q <= 1'b0;
        end

        START: begin
          if (bit_end) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= ser_lsb;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_q == LAST_BIT) begin
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= STOP_LVL;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= ser_lsb;
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= STOP_LVL;
          end
        end

        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            tx_q    <= IDLE_LVL;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          tx_q    <= IDLE_LVL;
          busy_q  <= 1'b0;
        end
      endcase

      // Acceptance overrides the case above: it applies from IDLE and also
      // replaces the STOP->IDLE step for a back-to-back frame.
      if (accept) begin
        state_q    <= START;
        cnt_q      <= '0;
        bit_q      <= '0;
        prescale_q <= eff_prescale(PRESCALE);
        par_en_q   <= PAR_EN;
        par_q      <= parity_bit(^P_DATA, PAR_TYP);
        tx_q       <= START_LVL;
        busy_q     <= 1'b1;
      end
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_top.sv
module tb_uart_tx_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  always #5 clk = ~clk;

  uart_tx_top #(
    .DSIZE (8)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .PRESCALE   (prescale),
    .TX_OUT     (tx_out),
    .BUSY       (busy)
  );

  // Stimulus record with hand-derived expectations (parity bit, BUSY length).
  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
    logic       exp_par;
    int         exp_n;
  } vec_t;

  // Scoreboard entry: expected line bits of one frame.
  typedef struct {
    logic [10:0] bits;
    int          p;
    int          n;
    bit          b2b;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   frames_done = 0;
  bit   mon_en = 1'b1;

  function automatic exp_t make_exp(input logic [7:0] d, input logic pe,
                                    input logic par, input logic [5:0] ps,
                                    input int n, input bit b2b);
    exp_t e;
    e.bits    = '1;            // stop bit (and unused tail) high
    e.bits[0] = 1'b0;          // start bit
    for (int i = 0; i < 8; i++) e.bits[1+i] = d[i];
    if (pe) e.bits[9] = par;
    e.p    = (ps == 6'd0) ? 1 : int'(ps);
    e.n    = n;
    e.b2b  = b2b;
    e.data = d;
    return e;
  endfunction

  // Monitor: detects each start bit, pops the scoreboard and checks every
  // cycle of the frame, then the cycle after it.
  initial begin : monitor
    logic line_prev;
    bit   start_here;
    exp_t e;
    int   bad;
    int   bad_c;
    logic bad_tx;
    logic bad_busy;
    logic bad_exp;
    logic exp_bit;
    line_prev  = 1'b1;
    start_here = 1'b0;
    forever begin
      if (!start_here) @(negedge clk);
      start_here = 1'b0;
      if (mon_en && line_prev && !tx_out) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: tx_out fell to %b with no frame pending, required idle line 1", tx_out);
          line_prev = tx_out;
          continue;
        end
        e     = sb.pop_front();
        bad   = 0;
        bad_c = 0; bad_tx = 1'b0; bad_busy = 1'b0; bad_exp = 1'b0;
        for (int c = 0; c < e.n; c++) begin
          if (c > 0) @(negedge clk);
          exp_bit = ((c / e.p) <= 10) ? e.bits[c / e.p] : 1'b1;
          if (tx_out !== exp_bit || busy !== 1'b1) begin
            if (bad == 0) begin
              bad_c = c; bad_tx = tx_out; bad_busy = busy; bad_exp = exp_bit;
            end
            bad++;
          end
        end
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL frame_bits data=%02h: cycle %0d tx_out=%b busy=%b, required tx_out=%b busy=1 (%0d bad cycles)",
                   e.data, bad_c, bad_tx, bad_busy, bad_exp, bad);
        end
        @(negedge clk);
        checks++;
        if (e.b2b) begin
          if (!(tx_out === 1'b0 && busy === 1'b1)) begin
            errors++;
            $display("FAIL frame_end_b2b data=%02h: tx_out=%b busy=%b, required tx_out=0 busy=1", e.data, tx_out, busy);
          end
          start_here = 1'b1;
          line_prev  = 1'b1;
        end else begin
          if (!(tx_out === 1'b1 && busy === 1'b0)) begin
            errors++;
            $display("FAIL frame_end data=%02h: tx_out=%b busy=%b, required tx_out=1 busy=0", e.data, tx_out, busy);
          end
          line_prev = tx_out;
        end
        frames_done++;
        $display("frame %0d data=%02h cycles=%0d bad_cycles=%0d", frames_done, e.data, e.n, bad);
        continue;
      end
      line_prev = tx_out;
    end
  end

  // Drives one request at a negedge, pushes its expectation, checks latency.
  // DATA_VALID is left high; the caller decides when to drop it.
  task automatic send_frame(input vec_t v, input bit b2b);
    sb.push_back(make_exp(v.data, v.par_en, v.exp_par, v.prescale, v.exp_n, b2b));
    p_data     = v.data;
    par_en     = v.par_en;
    par_typ    = v.par_typ;
    prescale   = v.prescale;
    data_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_latency data=%02h: tx_out=%b busy=%b, required tx_out=0 busy=1", v.data, tx_out, busy);
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int cyc;
    cyc = 0;
    while (frames_done < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL %s_timeout: frames_done=%0d after %0d cycles, required %0d", name, frames_done, cyc, target);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: tx_out=%b busy=%b, required tx_out=1 busy=0", name, tx_out, busy);
    end
  endtask

  initial begin : main
    int   done;
    vec_t v;
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = '0;

    //              data   pe    pt    ps     par   N
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 6'd8,  1'b0, 88};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 6'd8,  1'b0, 88};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 6'd8,  1'b1, 88};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 6'd16, 1'b0, 160};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 6'd0,  1'b0, 10};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 6'd3,  1'b1, 33};
    vecs[6] = '{8'h7E, 1'b1, 1'b1, 6'd5,  1'b1, 55};

    #1;
    check_idle("reset_state");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset_release");

    // Table-driven frames; inputs are scrambled mid-frame and must not matter.
    for (int i = 0; i < 7; i++) begin
      done = frames_done;
      send_frame(vecs[i], 1'b0);
      data_valid = 1'b0;
      p_data     = 8'($urandom);
      par_en     = ~vecs[i].par_en;
      par_typ    = ~vecs[i].par_typ;
      prescale   = 6'($urandom_range(1, 63));
      wait_frames(done + 1, vecs[i].exp_n + 20, "vec");
      repeat (2) @(negedge clk);
    end

    // Back-to-back: DATA_VALID held, P_DATA changed mid-frame.
    done = frames_done;
    v = '{8'h3C, 1'b0, 1'b0, 6'd4, 1'b0, 40};
    send_frame(v, 1'b1);
    repeat (20) @(negedge clk);
    p_data = 8'hC3;
    sb.push_back(make_exp(8'hC3, 1'b0, 1'b0, 6'd4, 40, 1'b0));
    wait_frames(done + 1, 60, "b2b_first");
    data_valid = 1'b0;
    wait_frames(done + 2, 60, "b2b_second");
    repeat (2) @(negedge clk);

    // Asynchronous reset during data bit 3 (A5 bit 3 is 0).
    mon_en     = 1'b0;
    p_data     = 8'hA5;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    prescale   = 6'd4;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (17) @(negedge clk);
    checks++;
    if (tx_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_bit3: tx_out=%b busy=%b, required tx_out=0 busy=1", tx_out, busy);
    end
    #2 rst = 1'b1;
    #1;
    check_idle("async_reset_immediate");
    $display("reset asserted mid-frame at %0t", $time);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle_after_reset");
    mon_en = 1'b1;
    @(negedge clk);
    done = frames_done;
    v = '{8'h5A, 1'b1, 1'b1, 6'd6, 1'b1, 66};
    send_frame(v, 1'b0);
    data_valid = 1'b0;
    wait_frames(done + 1, 90, "post_reset");

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d frames pending, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
